// File: rtl/load_issue_scheduler.sv
// load_issue_scheduler
//   Chooses one load-queue entry per cycle to send to the data cache port.
//   The choice is oldest-first, scanning from the LDQ head and wrapping.
//   This block owns the memory request valid/ready handshake.
//   Each accepted load is reported back to the LDQ through load_executed.
//   Optional feature macro: CONSERVATIVE_LOAD_ISSUE_EN. When it is defined,
//   a load may issue only once all of its older store-mask bits are clear.
module load_issue_scheduler #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned ROB_TAG_WIDTH = 32,
   parameter int unsigned LDQ_SIZE      = 32,
   parameter int unsigned STQ_SIZE      = 32,
   localparam int unsigned IDX_W        = $clog2(LDQ_SIZE)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   flush,
   input  logic [LDQ_SIZE-1:0]                    ldq_valid,
   input  logic [LDQ_SIZE-1:0]                    ldq_address_valid,
   input  logic [LDQ_SIZE-1:0]                    ldq_executed,
   input  logic [LDQ_SIZE-1:0][XLEN-1:0]          ldq_address,
   input  logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] ldq_rob_tag,
   input  logic [LDQ_SIZE-1:0][STQ_SIZE-1:0]      ldq_store_mask,
   input  logic [IDX_W-1:0]                       head,
   output logic                                   mem_req_valid,
   input  logic                                   mem_req_ready,
   output logic [XLEN-1:0]                        mem_req_address,
   output logic [ROB_TAG_WIDTH-1:0]               mem_req_rob_tag,
   output logic                                   load_executed,
   output logic [IDX_W-1:0]                       load_executed_index
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t              state, state_next;
   logic [IDX_W-1:0]    req_index;
   logic                handshake;
   logic                latch_req;
   logic [LDQ_SIZE-1:0] eligible;
   logic                sel_found;
   logic [IDX_W-1:0]    sel_index;
   logic [IDX_W-1:0]    scan_index;

`ifndef CONSERVATIVE_LOAD_ISSUE_EN
   logic unused_store_mask;
   assign unused_store_mask = ^ldq_store_mask;
`endif

   assign mem_req_valid       = (state == REQ);
   assign handshake           = mem_req_valid & mem_req_ready;
   assign load_executed       = handshake;
   assign load_executed_index = req_index;

   // Per-entry eligibility. An entry accepted this cycle is excluded here
   // because its LDQ executed bit is only set at the next edge.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < LDQ_SIZE; i++) begin
         eligible[i] = ldq_valid[i] & ldq_address_valid[i] & ~ldq_executed[i]
                       & ~(handshake && (IDX_W'(i) == req_index));
`ifdef CONSERVATIVE_LOAD_ISSUE_EN
         eligible[i] = eligible[i] & (ldq_store_mask[i] == '0);
`endif
      end
   end

   // Rotating priority scan: pick the first eligible entry at or after head.
   always_comb begin
      sel_found  = 1'b0;
      sel_index  = '0;
      scan_index = '0;
      for (int unsigned k = 0; k < LDQ_SIZE; k++) begin
         scan_index = head + IDX_W'(k);
         if (!sel_found && eligible[scan_index]) begin
            sel_found = 1'b1;
            sel_index = scan_index;
         end
      end
   end

   // Next-state logic and the decision to capture a new request.
   always_comb begin
      state_next = state;
      latch_req  = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found && !flush) begin
               latch_req  = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (flush) begin
               state_next = IDLE;
            end else if (handshake) begin
               if (sel_found) begin
                  latch_req = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and request registers. Request fields change only on a new capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= IDLE;
         req_index       <= '0;
         mem_req_address <= '0;
         mem_req_rob_tag <= '0;
      end else begin
         state <= state_next;
         if (latch_req) begin
            req_index       <= sel_index;
            mem_req_address <= ldq_address[sel_index];
            mem_req_rob_tag <= ldq_rob_tag[sel_index];
         end
      end
   end

endmodule
